// File: rtl/hs_mem_tdpram_arb.sv
// hs_mem_tdpram_arb: round-robin arbiter that maps NUM_REQ requesters onto
// the two ports of an external true dual-port RAM. It zero-fills the RAM after
// reset and routes read data back to the requester that asked for it.
module hs_mem_tdpram_arb #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int DATA_DEPTH    = 16,
    // 0 = BOOL_FALSE (read latency 1), 1 = BOOL_TRUE (read latency 2)
    parameter bit EN_OUTPUT_REG = 1'b0,
    localparam int ADDR_WIDTH   = $clog2(DATA_DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_wen,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_rdata,
    output logic                          init_busy,
    output logic                          ram_pa_ce,
    output logic                          ram_pb_ce,
    output logic [ADDR_WIDTH-1:0]         ram_pa_addr,
    output logic [ADDR_WIDTH-1:0]         ram_pb_addr,
    output logic [DATA_WIDTH-1:0]         ram_pa_wdata,
    output logic [DATA_WIDTH-1:0]         ram_pb_wdata,
    output logic                          ram_pa_wen,
    output logic                          ram_pb_wen,
    input  logic [DATA_WIDTH-1:0]         ram_pa_rdata,
    input  logic [DATA_WIDTH-1:0]         ram_pb_rdata
);

    localparam int LAT   = EN_OUTPUT_REG ? 2 : 1;
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [ADDR_WIDTH-1:0] K_LAST    = ADDR_WIDTH'(DATA_DEPTH / 2 - 1);
    localparam logic [PTR_W:0]        NUM_REQ_P = (PTR_W + 1)'(NUM_REQ);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_k;
    logic [PTR_W-1:0]        r_ptr;
    logic [PTR_W-1:0]        w_ptr_nxt;

    // Per-port tag pipelines: stage LAT-1 lines up with the RAM read data.
    logic [LAT-1:0]          r_tag_a_vld;
    logic [LAT-1:0]          r_tag_b_vld;
    logic [PTR_W-1:0]        r_tag_a_id [LAT];
    logic [PTR_W-1:0]        r_tag_b_id [LAT];

    logic [PTR_W:0]          w_off [NUM_REQ];
    logic                    w_a_found;
    logic                    w_b_found;
    logic                    w_b_ok;
    logic [PTR_W-1:0]        w_a_id;
    logic [PTR_W-1:0]        w_b_id;
    logic [NUM_REQ-1:0]      w_gnt_a;
    logic [NUM_REQ-1:0]      w_gnt_b;
    logic [ADDR_WIDTH-1:0]   w_a_addr;
    logic [ADDR_WIDTH-1:0]   w_b_addr;
    logic [DATA_WIDTH-1:0]   w_a_wdata;
    logic [DATA_WIDTH-1:0]   w_b_wdata;
    logic                    w_a_wen;
    logic                    w_b_wen;

    // State register and zero-fill counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of every other flop.
        if (rst) begin
            r_state <= ST_INIT;
            r_k     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) begin
                r_k <= (r_k == K_LAST) ? '0 : r_k + ADDR_WIDTH'(1);
            end
        end
    end

    // Next-state: leave INIT once the last address pair has been written.
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_INIT && r_k == K_LAST) begin
            w_state_nxt = ST_RUN;
        end
    end

    // Candidate search: order requesters by distance from ptr, take the first two valid.
    always_comb begin
        logic [PTR_W:0] w_sum;
        // NOTE: every combinational output gets a default first, otherwise
        // paths that skip an assignment infer a latch.
        w_sum     = '0;
        w_a_found = 1'b0;
        w_b_found = 1'b0;
        w_a_id    = '0;
        w_b_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum    = (PTR_W + 1)'(i + NUM_REQ) - {1'b0, r_ptr};
            w_off[i] = (w_sum >= NUM_REQ_P) ? (w_sum - NUM_REQ_P) : w_sum;
        end
        for (int o = 0; o < NUM_REQ; o++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && (w_off[i] == (PTR_W + 1)'(o))) begin
                    if (!w_a_found) begin
                        w_a_found = 1'b1;
                        w_a_id    = PTR_W'(i);
                    end else if (!w_b_found) begin
                        w_b_found = 1'b1;
                        w_b_id    = PTR_W'(i);
                    end
                end
            end
        end
    end

    // Grant decode, request muxing, conflict check and next pointer.
    always_comb begin
        logic [PTR_W-1:0] w_last;
        logic [PTR_W:0]   w_last_p1;
        w_a_addr  = '0;
        w_b_addr  = '0;
        w_a_wdata = '0;
        w_b_wdata = '0;
        w_a_wen   = 1'b0;
        w_b_wen   = 1'b0;
        w_gnt_a   = '0;
        w_gnt_b   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_a_found && w_a_id == PTR_W'(i)) begin
                w_a_addr   = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_a_wdata  = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_a_wen    = req_wen[i];
                w_gnt_a[i] = 1'b1;
            end
            if (w_b_found && w_b_id == PTR_W'(i)) begin
                w_b_addr   = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_b_wdata  = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_b_wen    = req_wen[i];
                w_gnt_b[i] = 1'b1;
            end
        end
        // Same address with any write would race inside the RAM: only A goes.
        w_b_ok    = w_b_found && !((w_a_addr == w_b_addr) && (w_a_wen || w_b_wen));
        w_gnt_b   = w_b_ok ? w_gnt_b : '0;
        w_last    = w_b_ok ? w_b_id : w_a_id;
        w_last_p1 = {1'b0, w_last} + (PTR_W + 1)'(1);
        w_ptr_nxt = (w_last_p1 == NUM_REQ_P) ? '0 : w_last_p1[PTR_W-1:0];
    end

    // Outputs: RAM port drive, handshake and init status, all forced idle in reset.
    always_comb begin
        ram_pa_ce    = !rst;
        ram_pb_ce    = !rst;
        ram_pa_wen   = 1'b0;
        ram_pb_wen   = 1'b0;
        ram_pa_addr  = '0;
        ram_pb_addr  = '0;
        ram_pa_wdata = '0;
        ram_pb_wdata = '0;
        req_ready    = '0;
        init_busy    = 1'b1;
        if (!rst) begin
            if (r_state == ST_INIT) begin
                ram_pa_wen  = 1'b1;
                ram_pb_wen  = 1'b1;
                ram_pa_addr = r_k << 1;
                ram_pb_addr = (r_k << 1) | ADDR_WIDTH'(1);
            end else begin
                init_busy = 1'b0;
                req_ready = w_gnt_a | w_gnt_b;
                if (w_a_found) begin
                    ram_pa_wen   = w_a_wen;
                    ram_pa_addr  = w_a_addr;
                    ram_pa_wdata = w_a_wdata;
                end
                if (w_b_ok) begin
                    ram_pb_wen   = w_b_wen;
                    ram_pb_addr  = w_b_addr;
                    ram_pb_wdata = w_b_wdata;
                end
            end
        end
    end

    // Round-robin pointer and read-tag pipelines.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the tags are control state, so they are cleared to drop
            // reads in flight; the RAM contents are never reset, only zero-filled.
            r_ptr       <= '0;
            r_tag_a_vld <= '0;
            r_tag_b_vld <= '0;
            for (int s = 0; s < LAT; s++) begin
                r_tag_a_id[s] <= '0;
                r_tag_b_id[s] <= '0;
            end
        end else begin
            if (r_state == ST_RUN && w_a_found) begin
                r_ptr <= w_ptr_nxt;
            end
            r_tag_a_vld[0] <= (r_state == ST_RUN) && w_a_found && !w_a_wen;
            r_tag_b_vld[0] <= (r_state == ST_RUN) && w_b_ok && !w_b_wen;
            r_tag_a_id[0]  <= w_a_id;
            r_tag_b_id[0]  <= w_b_id;
            for (int s = 1; s < LAT; s++) begin
                r_tag_a_vld[s] <= r_tag_a_vld[s-1];
                r_tag_b_vld[s] <= r_tag_b_vld[s-1];
                r_tag_a_id[s]  <= r_tag_a_id[s-1];
                r_tag_b_id[s]  <= r_tag_b_id[s-1];
            end
        end
    end

    // Response routing: each port's returning read goes to its tagged requester.
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (r_tag_a_vld[LAT-1] && r_tag_a_id[LAT-1] == PTR_W'(i)) begin
                    rsp_valid[i]                           = 1'b1;
                    rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = ram_pa_rdata;
                end
                if (r_tag_b_vld[LAT-1] && r_tag_b_id[LAT-1] == PTR_W'(i)) begin
                    rsp_valid[i]                           = 1'b1;
                    rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = ram_pb_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_hs_mem_tdpram_arb.sv
// tb_hs_mem_tdpram_arb: directed scenarios followed by random traffic, all
// compared cycle by cycle against a transaction-level model of the arbiter.
module tb_hs_mem_tdpram_arb;

    localparam int NUM_REQ = 4;
    localparam int DW      = 8;
    localparam int DEPTH   = 16;
    localparam bit EN_OR   = 1'b0;
    localparam int LAT     = EN_OR ? 2 : 1;
    localparam int AW      = $clog2(DEPTH);

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ-1:0]     req_wen;
    logic [NUM_REQ*AW-1:0]  req_addr;
    logic [NUM_REQ*DW-1:0]  req_wdata;
    logic [NUM_REQ-1:0]     rsp_valid;
    logic [NUM_REQ*DW-1:0]  rsp_rdata;
    logic                   init_busy;
    logic                   ram_pa_ce, ram_pb_ce;
    logic [AW-1:0]          ram_pa_addr, ram_pb_addr;
    logic [DW-1:0]          ram_pa_wdata, ram_pb_wdata;
    logic                   ram_pa_wen, ram_pb_wen;
    logic [DW-1:0]          ram_pa_rdata, ram_pb_rdata;

    always #5 clk = ~clk;

    hs_mem_tdpram_arb #(
        .NUM_REQ      (NUM_REQ),
        .DATA_WIDTH   (DW),
        .DATA_DEPTH   (DEPTH),
        .EN_OUTPUT_REG(EN_OR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wen     (req_wen),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .init_busy   (init_busy),
        .ram_pa_ce   (ram_pa_ce),
        .ram_pb_ce   (ram_pb_ce),
        .ram_pa_addr (ram_pa_addr),
        .ram_pb_addr (ram_pb_addr),
        .ram_pa_wdata(ram_pa_wdata),
        .ram_pb_wdata(ram_pb_wdata),
        .ram_pa_wen  (ram_pa_wen),
        .ram_pb_wen  (ram_pb_wen),
        .ram_pa_rdata(ram_pa_rdata),
        .ram_pb_rdata(ram_pb_rdata)
    );

    // Attached RAM: true dual port, read-first, optional output register.
    logic [DW-1:0] ram_mem [DEPTH];
    logic [DW-1:0] ram_a_q, ram_b_q, ram_a_q2, ram_b_q2;

    always @(posedge clk) begin
        if (ram_pa_ce) begin
            if (ram_pa_wen) ram_mem[ram_pa_addr] <= ram_pa_wdata;
            ram_a_q  <= ram_mem[ram_pa_addr];
            ram_a_q2 <= ram_a_q;
        end
        if (ram_pb_ce) begin
            if (ram_pb_wen) ram_mem[ram_pb_addr] <= ram_pb_wdata;
            ram_b_q  <= ram_mem[ram_pb_addr];
            ram_b_q2 <= ram_b_q;
        end
    end

    assign ram_pa_rdata = (LAT == 2) ? ram_a_q2 : ram_a_q;
    assign ram_pb_rdata = (LAT == 2) ? ram_b_q2 : ram_b_q;

    // Reference model state.
    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } rsp_t;

    logic [DW-1:0] m_mem [DEPTH];
    rsp_t          m_q[$];
    int            m_ptr;
    bit            m_init;
    int            m_k;
    int            cyc;
    int            n_tests;
    int            n_fail;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input logic [NUM_REQ*AW-1:0] a, input int i);
        return a[i*AW +: AW];
    endfunction

    // One clock cycle: drive after the edge, compare at the falling edge, advance the model.
    task automatic run_cycle(input bit r, input logic [NUM_REQ-1:0] v, input logic [NUM_REQ-1:0] we,
                             input logic [NUM_REQ*AW-1:0] a, input logic [NUM_REQ*DW-1:0] d);
        int                    order[$];
        int                    ga;
        int                    gb;
        int                    last;
        logic [NUM_REQ-1:0]    e_rdy;
        logic [NUM_REQ-1:0]    e_rv;
        logic [NUM_REQ*DW-1:0] e_rd;
        logic                  e_awen, e_bwen;
        logic [AW-1:0]         e_aaddr, e_baddr;
        logic [DW-1:0]         e_ad, e_bd;

        @(posedge clk);
        #1;
        rst       = r;
        req_valid = v;
        req_wen   = we;
        req_addr  = a;
        req_wdata = d;
        cyc++;
        @(negedge clk);

        e_rv = '0;
        e_rd = '0;
        if (!r) begin
            for (int i = m_q.size() - 1; i >= 0; i--) begin
                if (m_q[i].due == cyc) begin
                    e_rv[m_q[i].id]            = 1'b1;
                    e_rd[m_q[i].id*DW +: DW]   = m_q[i].data;
                    m_q.delete(i);
                end
            end
        end
        check("rsp_valid", rsp_valid, e_rv);
        check("rsp_rdata", rsp_rdata, e_rd);

        if (r) begin
            check("rst_ready", req_ready, 0);
            check("rst_busy", init_busy, 1);
            check("rst_ce", {ram_pa_ce, ram_pb_ce}, 0);
            check("rst_wen", {ram_pa_wen, ram_pb_wen}, 0);
            m_q.delete();
            m_ptr  = 0;
            m_init = 1'b1;
            m_k    = 0;
        end else if (m_init) begin
            check("init_busy", init_busy, 1);
            check("init_ready", req_ready, 0);
            check("init_ce", {ram_pa_ce, ram_pb_ce}, 2'b11);
            check("init_wen", {ram_pa_wen, ram_pb_wen}, 2'b11);
            check("init_pa_addr", ram_pa_addr, 2 * m_k);
            check("init_pb_addr", ram_pb_addr, 2 * m_k + 1);
            check("init_wdata", {ram_pa_wdata, ram_pb_wdata}, 0);
            m_mem[2*m_k]   = '0;
            m_mem[2*m_k+1] = '0;
            m_k++;
            if (m_k == DEPTH / 2) m_init = 1'b0;
        end else begin
            for (int j = 0; j < NUM_REQ; j++) begin
                int idx;
                idx = (m_ptr + j) % NUM_REQ;
                if (v[idx]) order.push_back(idx);
            end
            ga = (order.size() > 0) ? order[0] : -1;
            gb = (order.size() > 1) ? order[1] : -1;
            if (gb >= 0 && addr_of(a, ga) == addr_of(a, gb) && (we[ga] || we[gb])) gb = -1;

            e_rdy   = '0;
            e_awen  = 1'b0;
            e_bwen  = 1'b0;
            e_aaddr = '0;
            e_baddr = '0;
            e_ad    = '0;
            e_bd    = '0;
            if (ga >= 0) begin
                e_rdy[ga] = 1'b1;
                e_awen    = we[ga];
                e_aaddr   = addr_of(a, ga);
                e_ad      = d[ga*DW +: DW];
            end
            if (gb >= 0) begin
                e_rdy[gb] = 1'b1;
                e_bwen    = we[gb];
                e_baddr   = addr_of(a, gb);
                e_bd      = d[gb*DW +: DW];
            end

            check("run_busy", init_busy, 0);
            check("ready", req_ready, e_rdy);
            check("ce", {ram_pa_ce, ram_pb_ce}, 2'b11);
            check("pa_wen", ram_pa_wen, e_awen);
            check("pb_wen", ram_pb_wen, e_bwen);
            check("pa_addr", ram_pa_addr, e_aaddr);
            check("pb_addr", ram_pb_addr, e_baddr);
            check("pa_wdata", ram_pa_wdata, e_ad);
            check("pb_wdata", ram_pb_wdata, e_bd);

            // Reads see memory as it was before this cycle's writes.
            if (ga >= 0 && !e_awen) m_q.push_back('{cyc + LAT, ga, m_mem[e_aaddr]});
            if (gb >= 0 && !e_bwen) m_q.push_back('{cyc + LAT, gb, m_mem[e_baddr]});
            if (ga >= 0 && e_awen) m_mem[e_aaddr] = e_ad;
            if (gb >= 0 && e_bwen) m_mem[e_baddr] = e_bd;
            last = (gb >= 0) ? gb : ga;
            if (last >= 0) m_ptr = (last + 1) % NUM_REQ;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0, '0, '0, '0, '0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_wen   = '0;
        req_addr  = '0;
        req_wdata = '0;
        cyc       = 0;
        n_tests   = 0;
        n_fail    = 0;
        m_ptr     = 0;
        m_init    = 1'b1;
        m_k       = 0;

        // Reset with requests pending: nothing may be granted.
        run_cycle(1'b1, 4'b1111, 4'b0000, '0, '0);
        run_cycle(1'b1, 4'b1111, 4'b1111, '0, '0);

        // Zero-fill with all requesters valid; ready must stay low.
        for (int i = 0; i < DEPTH / 2; i++) run_cycle(1'b0, 4'b1111, 4'b0000, '0, '0);

        // All four read, ptr = 0: pairs {0,1}, {2,3}, {0,1}.
        for (int i = 0; i < 3; i++)
            run_cycle(1'b0, 4'b1111, 4'b0000, {4'd7, 4'd6, 4'd5, 4'd4}, '0);

        // Only req3 valid: port A, port B idle, ptr wraps to 0.
        run_cycle(1'b0, 4'b1000, 4'b0000, {4'd9, 4'd0, 4'd0, 4'd0}, '0);

        // req0 writes addr 3 = 0xA5, req1 reads it on the next cycle.
        run_cycle(1'b0, 4'b0001, 4'b0001, {4'd0, 4'd0, 4'd0, 4'd3}, {8'h00, 8'h00, 8'h00, 8'hA5});
        run_cycle(1'b0, 4'b0010, 4'b0000, {4'd0, 4'd0, 4'd3, 4'd0}, '0);
        idle(2);

        // Bring ptr back to 0, then same-address write/read conflict.
        run_cycle(1'b0, 4'b1000, 4'b0000, {4'd1, 4'd0, 4'd0, 4'd0}, '0);
        run_cycle(1'b0, 4'b0101, 4'b0001, {4'd0, 4'd5, 4'd0, 4'd5}, {8'h00, 8'h00, 8'h00, 8'h3C});
        run_cycle(1'b0, 4'b0100, 4'b0000, {4'd0, 4'd5, 4'd0, 4'd0}, '0);
        idle(2);

        // A read in flight when reset hits must never respond.
        run_cycle(1'b0, 4'b0100, 4'b0000, {4'd0, 4'd3, 4'd0, 4'd0}, '0);
        run_cycle(1'b1, 4'b0000, 4'b0000, '0, '0);
        idle(DEPTH / 2 + 3);

        // Random traffic on a narrow address range for conflicts and RAW.
        for (int n = 0; n < 400; n++) begin
            logic [NUM_REQ-1:0]    v;
            logic [NUM_REQ-1:0]    we;
            logic [NUM_REQ*AW-1:0] a;
            logic [NUM_REQ*DW-1:0] d;
            v  = NUM_REQ'($urandom);
            we = NUM_REQ'($urandom);
            d  = (NUM_REQ * DW)'($urandom);
            for (int i = 0; i < NUM_REQ; i++) a[i*AW +: AW] = AW'($urandom_range(0, 3));
            run_cycle($urandom_range(0, 99) == 0, v, we, a, d);
        end
        idle(LAT + 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
